// File: rtl/drac_pkg.sv
// Shared pipeline types for the fetch/decode boundary and the ID-stage queue depth.
package drac_pkg;

    localparam int unsigned XLEN              = 64;
    localparam int unsigned INSTR_QUEUE_DEPTH = 4;

    typedef logic [XLEN-1:0] bus64_t;
    typedef logic [31:0]     riscv_inst_t;

    typedef enum logic [3:0] {
        INSTR_ADDR_MISALIGNED = 4'd0,
        INSTR_ACCESS_FAULT    = 4'd1,
        ILLEGAL_INSTR         = 4'd2,
        BREAKPOINT            = 4'd3,
        INSTR_PAGE_FAULT      = 4'd12,
        NONE                  = 4'd15
    } exception_cause_t;

    typedef struct packed {
        exception_cause_t cause;
        bus64_t           origin;
        logic             valid;
    } exception_t;

    typedef enum logic {
        PRED_NOT_TAKEN = 1'b0,
        PRED_TAKEN     = 1'b1
    } branch_pred_decision_t;

    typedef struct packed {
        branch_pred_decision_t decision;
        bus64_t                pred_addr;
    } branch_pred_t;

    typedef struct packed {
        bus64_t       pc_inst;
        riscv_inst_t  inst;
        logic         valid;
        exception_t   ex;
        branch_pred_t bpred;
    } if_id_stage_t;

endpackage

// File: rtl/instr_queue.sv
// Fetch-to-decode decoupling FIFO; holds fetch off behind a faulting entry until it is consumed.
module instr_queue
    import drac_pkg::*;
#(
    parameter int unsigned DEPTH = INSTR_QUEUE_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               fetch_valid_i,
    input  if_id_stage_t       fetch_data_i,
    output logic               fetch_ready_o,
    input  logic               decode_ready_i,
    output if_id_stage_t       decode_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if_id_stage_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ex_pending_q, ex_pending_d;
    logic             push, pop;

    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == FULL_CNT);
    assign count_o       = count_q;
    // Ready looks only at registered state so decode back-pressure never reaches fetch combinationally.
    assign fetch_ready_o = !rst_i && !full_o && !ex_pending_q;

    assign push = fetch_valid_i && fetch_ready_o && !flush_i;
    assign pop  = decode_ready_i && !empty_o && !flush_i;

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        ex_pending_d = ex_pending_q;
        if (flush_i) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            ex_pending_d = 1'b0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (pop && mem_q[head_q].ex.valid) ex_pending_d = 1'b0;
            if (push && fetch_data_i.ex.valid) ex_pending_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ex_pending_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ex_pending_q <= ex_pending_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the empty check below masks stale contents.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[tail_q] <= fetch_data_i;
    end

    always_comb begin
        decode_o = '0;
        if (!empty_o) decode_o = mem_q[head_q];
    end

    logic [PTR_W-1:0] ptr_diff;
    assign ptr_diff = tail_q - head_q;

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && empty_o));
    a_count_ptrs:   assert property (@(posedge clk_i) disable iff (rst_i)
                        count_q == (full_o ? FULL_CNT : CNT_W'(ptr_diff)));

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue with hand-computed expectations.
module tb_instr_queue;
    import drac_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             fetch_valid_i;
    if_id_stage_t     fetch_data_i;
    logic             fetch_ready_o;
    logic             decode_ready_i;
    if_id_stage_t     decode_o;
    logic [CNT_W-1:0] count_o;
    logic             empty_o;
    logic             full_o;

    int n_cmp = 0;
    int n_err = 0;

    instr_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_data_i   (fetch_data_i),
        .fetch_ready_o  (fetch_ready_o),
        .decode_ready_i (decode_ready_i),
        .decode_o       (decode_o),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .full_o         (full_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic if_id_stage_t mk(input logic [63:0] pc, input logic [31:0] inst,
                                        input logic exv);
        if_id_stage_t e;
        e           = '0;
        e.pc_inst   = pc;
        e.inst      = inst;
        e.valid     = 1'b1;
        e.ex.valid  = exv;
        e.ex.cause  = exv ? ILLEGAL_INSTR : NONE;
        e.ex.origin = exv ? pc : 64'd0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    logic [31:0] insts [4];

    initial begin
        insts[0] = 32'hfff02013;
        insts[1] = 32'h00003013;
        insts[2] = 32'h00500013;
        insts[3] = 32'h00804013;

        rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0;
        fetch_data_i = '0; decode_ready_i = 1'b0;
        step(); step();
        check("rst_ready",  64'(fetch_ready_o), 64'd0);
        check("rst_count",  64'(count_o), 64'd0);
        check("rst_empty",  64'(empty_o), 64'd1);
        check("rst_full",   64'(full_o), 64'd0);
        check("rst_decode", 64'(decode_o === if_id_stage_t'('0)), 64'd1);
        rst_i = 1'b0;
        #1;
        check("rel_ready", 64'(fetch_ready_o), 64'd1);

        // Single push, decoder blocked.
        fetch_valid_i = 1'b1; fetch_data_i = mk(64'h2000, insts[0], 1'b0);
        step();
        fetch_valid_i = 1'b0;
        check("one_pc",    decode_o.pc_inst, 64'h2000);
        check("one_inst",  64'(decode_o.inst), 64'hfff02013);
        check("one_valid", 64'(decode_o.valid), 64'd1);
        check("one_count", 64'(count_o), 64'd1);
        decode_ready_i = 1'b1;
        step();
        decode_ready_i = 1'b0;
        check("one_empty", 64'(empty_o), 64'd1);

        // Fill to full, offer a fifth, then drain.
        for (int i = 0; i < 4; i++) begin
            fetch_valid_i = 1'b1;
            fetch_data_i  = mk(64'h2000 + 64'(4 * i), insts[i], 1'b0);
            step();
        end
        check("full_flag",  64'(full_o), 64'd1);
        check("full_ready", 64'(fetch_ready_o), 64'd0);
        check("full_count", 64'(count_o), 64'd4);
        fetch_data_i = mk(64'h2010, 32'h00000013, 1'b0);
        step();
        fetch_valid_i = 1'b0;
        check("fifth_count", 64'(count_o), 64'd4);
        check("fifth_head",  decode_o.pc_inst, 64'h2000);
        decode_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc",   decode_o.pc_inst, 64'h2000 + 64'(4 * i));
            check("drain_inst", 64'(decode_o.inst), 64'(insts[i]));
            step();
            if (i == 0) check("ready_after_pop", 64'(fetch_ready_o), 64'd1);
        end
        decode_ready_i = 1'b0;
        check("drain_empty", 64'(empty_o), 64'd1);
        check("drain_valid", 64'(decode_o.valid), 64'd0);

        // Streaming: push and pop every cycle, decoder one cycle behind fetch.
        decode_ready_i = 1'b1;
        fetch_valid_i  = 1'b1;
        fetch_data_i   = mk(64'h3000, 32'h00000013, 1'b0);
        step();
        for (int k = 1; k <= 10; k++) begin
            check("stream_pc",    decode_o.pc_inst, 64'h3000 + 64'(4 * (k - 1)));
            check("stream_count", 64'(count_o), 64'd1);
            if (k < 10) fetch_data_i = mk(64'h3000 + 64'(4 * k), 32'h00000013, 1'b0);
            else        fetch_valid_i = 1'b0;
            step();
        end
        decode_ready_i = 1'b0;
        check("stream_empty", 64'(empty_o), 64'd1);

        // Faulting entry blocks fetch until consumed.
        fetch_valid_i = 1'b1; fetch_data_i = mk(64'h4000, 32'h00000000, 1'b1);
        step();
        check("ex_ready",  64'(fetch_ready_o), 64'd0);
        check("ex_flag",   64'(decode_o.ex.valid), 64'd1);
        fetch_data_i = mk(64'h4004, 32'h00000013, 1'b0);
        step();
        fetch_valid_i = 1'b0;
        check("ex_block_count", 64'(count_o), 64'd1);
        decode_ready_i = 1'b1;
        step();
        decode_ready_i = 1'b0;
        check("ex_pop_ready", 64'(fetch_ready_o), 64'd1);
        check("ex_pop_count", 64'(count_o), 64'd0);

        // Flush wins over a simultaneous push and pop.
        for (int i = 0; i < 3; i++) begin
            fetch_valid_i = 1'b1;
            fetch_data_i  = mk(64'h6000 + 64'(4 * i), 32'h00000013, 1'b0);
            step();
        end
        check("pre_flush_count", 64'(count_o), 64'd3);
        flush_i = 1'b1; decode_ready_i = 1'b1;
        fetch_data_i = mk(64'h5000, 32'h00000013, 1'b0);
        step();
        flush_i = 1'b0; fetch_valid_i = 1'b0; decode_ready_i = 1'b0;
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(decode_o.valid), 64'd0);
        step();
        check("flush_stays_empty", 64'(count_o), 64'd0);
        check("flush_no_5000",     decode_o.pc_inst, 64'd0);

        // Reset mid-stream.
        for (int i = 0; i < 2; i++) begin
            fetch_valid_i = 1'b1;
            fetch_data_i  = mk(64'h7100 + 64'(4 * i), 32'h00000013, 1'b0);
            step();
        end
        fetch_valid_i = 1'b0;
        check("pre_rst_count", 64'(count_o), 64'd2);
        rst_i = 1'b1;
        #1;
        check("rst_hold_ready", 64'(fetch_ready_o), 64'd0);
        step();
        check("mid_rst_count", 64'(count_o), 64'd0);
        check("mid_rst_ready", 64'(fetch_ready_o), 64'd0);
        check("mid_rst_valid", 64'(decode_o.valid), 64'd0);
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", 64'(fetch_ready_o), 64'd1);
        fetch_valid_i = 1'b1; fetch_data_i = mk(64'h7000, 32'h00000013, 1'b0);
        step();
        fetch_valid_i = 1'b0;
        check("post_rst_pc",    decode_o.pc_inst, 64'h7000);
        check("post_rst_count", 64'(count_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
